// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the segmented pipelined adder: operating modes and stage-count derivation.
package pipe_adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int stages_of(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/seg_adder.sv
// SEG-bit ripple-carry segment adder. Reports the carry out, the carry into the MSB,
// and the segment's group propagate and generate.
module seg_adder
    import pipe_adder_pkg::*;
#(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb,
    output logic           p,
    output logic           g
);

    logic [SEG:0] c;
    logic [SEG:0] gc;

    // NOTE: combinational logic uses blocking assignments, with every output
    // given a default first so that no latch is inferred.
    always_comb begin
        c     = '0;
        gc    = '0;
        sum   = '0;
        c[0]  = cin;
        for (int i = 0; i < SEG; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
            gc[i+1] = (a[i] & b[i]) | (gc[i] & (a[i] ^ b[i]));
        end
    end

    // The generate chain starts from zero, so g is independent of cin.
    assign cout  = c[SEG];
    assign c_msb = c[SEG-1];
    assign p     = &(a ^ b);
    assign g     = gc[SEG];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor. Stage k adds segment k; operands are skewed in and sums deskewed out,
// and the whole pipe advances as one unit under valid/ready flow control.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_p,
    output logic             out_g
);

    localparam int STAGES = stages_of(WIDTH, SEG);

    if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_seg
        $error("pipe_adder: WIDTH must be a positive multiple of SEG");
    end

    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] sum_in [STAGES];
    logic             c_in   [STAGES];
    logic             p_in   [STAGES];
    logic             g_in   [STAGES];
    logic             v_in   [STAGES];

    logic [SEG-1:0]   seg_sum  [STAGES];
    logic             seg_cout [STAGES];
    logic             seg_cmsb [STAGES];
    logic             seg_p    [STAGES];
    logic             seg_g    [STAGES];

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             c_q   [STAGES];
    logic             p_q   [STAGES];
    logic             g_q   [STAGES];
    logic             ovf_q [STAGES];
    logic             v_q   [STAGES];

    logic advance;

    // The pipe moves only as a whole: a stall freezes every stage.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in[k]   = a;
            assign b_in[k]   = (sub == SUB) ? ~b : b;
            assign sum_in[k] = '0;
            assign c_in[k]   = (sub == SUB) ? 1'b1 : cin;
            assign p_in[k]   = 1'b1;
            assign g_in[k]   = 1'b0;
            assign v_in[k]   = in_valid;
        end else begin : g_body
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign sum_in[k] = sum_q[k-1];
            assign c_in[k]   = c_q[k-1];
            assign p_in[k]   = p_q[k-1];
            assign g_in[k]   = g_q[k-1];
            assign v_in[k]   = v_q[k-1];
        end

        seg_adder #(.SEG(SEG)) u_seg (
            .a     (a_in[k][k*SEG +: SEG]),
            .b     (b_in[k][k*SEG +: SEG]),
            .cin   (c_in[k]),
            .sum   (seg_sum[k]),
            .cout  (seg_cout[k]),
            .c_msb (seg_cmsb[k]),
            .p     (seg_p[k]),
            .g     (seg_g[k])
        );
    end

    // NOTE: all pipeline state uses non-blocking assignments; stage data is
    // cleared on reset along with the valid bits so the out_* ports read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
                p_q[k]   <= 1'b0;
                g_q[k]   <= 1'b0;
                ovf_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= v_in[k];
                a_q[k]   <= a_in[k];
                b_q[k]   <= b_in[k];
                sum_q[k] <= sum_in[k];
                sum_q[k][k*SEG +: SEG] <= seg_sum[k];
                c_q[k]   <= seg_cout[k];
                p_q[k]   <= p_in[k] & seg_p[k];
                g_q[k]   <= seg_g[k] | (seg_p[k] & g_in[k]);
                ovf_q[k] <= seg_cmsb[k] ^ seg_cout[k];
            end
        end
    end

    // Only the last stage's overflow is meaningful: it sees the word's MSB.
    assign out_valid = v_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];
    assign out_ovf   = ovf_q[STAGES-1];
    assign out_p     = p_q[STAGES-1];
    assign out_g     = g_q[STAGES-1];

endmodule
